unidade_controle: RTL

Multi-cycle control FSM for the RV64I core. It consumes the instruction word held by the instruction register (`doutIR`) and the ALU zero flag. It generates the strobes and mux selects that drive the PC/IR update (`atualiza_pc`), data memory (`WeDM`), register file and ALU. It sits directly downstream of the memory stage and closes the fetch loop by pulsing `atualiza_pc` once per instruction.

---
 rtl/unidade_controle_if.sv | 28 ++
 rtl/unidade_controle.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_if.sv
// Control-unit bundle: instruction word and ALU flag in, datapath strobes and selects out.
// The controller binds the master modport; the datapath side binds slave.
interface unidade_controle_if;
    logic [31:0] doutIR;
    logic        zero;
    logic        atualiza_pc;
    logic        WeDM;
    logic        WeRF;
    logic        selULA_B;
    logic [1:0]  selRF;
    logic        selPC;
    logic [3:0]  opULA;
    logic [2:0]  tipo_imm;
    logic [2:0]  estado;
    logic        erro;

    modport master (
        input  doutIR, zero,
        output atualiza_pc, WeDM, WeRF, selULA_B, selRF, selPC,
               opULA, tipo_imm, estado, erro
    );

    modport slave (
        output doutIR, zero,
        input  atualiza_pc, WeDM, WeRF, selULA_B, selRF, selPC,
               opULA, tipo_imm, estado, erro
    );
endinterface

// File: rtl/unidade_controle.sv
// Multi-cycle RV64I control FSM; strobes are flops, selects decode combinationally from doutIR.
// Latency: 3 cycles/branch, 4 for R/I/LUI/JAL/SD, 5 for LD; no backpressure, one atualiza_pc pulse per instruction.
// CONTROLE_TRAP_EN: illegal instructions park in ERRO until reset; otherwise they retire as NOPs.
module unidade_controle #(
    parameter int XLEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    unidade_controle_if.master ctl
);
    typedef enum logic [2:0] {
        INICIO  = 3'd0,
        BUSCA   = 3'd1,
        DECOD   = 3'd2,
        EXEC    = 3'd3,
        MEM     = 3'd4,
        ESCRITA = 3'd5,
        ERRO    = 3'd6
    } estado_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [3:0] ULA_ADD    = 4'd0;
    localparam logic [3:0] ULA_SUB    = 4'd1;
    localparam logic [3:0] ULA_AND    = 4'd2;
    localparam logic [3:0] ULA_OR     = 4'd3;
    localparam logic [3:0] ULA_XOR    = 4'd4;
    localparam logic [3:0] ULA_SLL    = 4'd5;
    localparam logic [3:0] ULA_SRL    = 4'd6;
    localparam logic [3:0] ULA_SRA    = 4'd7;
    localparam logic [3:0] ULA_SLT    = 4'd8;
    localparam logic [3:0] ULA_SLTU   = 4'd9;
    localparam logic [3:0] ULA_PASS_B = 4'd10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // The decoder only ever looks at the 32-bit instruction word.
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_unsupported
    end

    estado_t estado_q, estado_d;
    logic    atualiza_pc_q, atualiza_pc_d;
    logic    wedm_q, wedm_d;
    logic    werf_q, werf_d;
    logic    desvio_q, desvio_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [4:0] rd;
    logic       unused_bits;

    assign opcode      = ctl.doutIR[6:0];
    assign rd          = ctl.doutIR[11:7];
    assign funct3      = ctl.doutIR[14:12];
    assign funct7_5    = ctl.doutIR[30];
    assign unused_bits = ^{ctl.doutIR[31], ctl.doutIR[29:15]};

    logic is_r, is_i, is_ld, is_sd, is_beq, is_bne, is_br, is_jal, is_lui, legal;

    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_ld  = (opcode == OP_LD) && (funct3 == 3'b011);
    assign is_sd  = (opcode == OP_SD) && (funct3 == 3'b011);
    assign is_beq = (opcode == OP_BR) && (funct3 == 3'b000);
    assign is_bne = (opcode == OP_BR) && (funct3 == 3'b001);
    assign is_br  = is_beq || is_bne;
    assign is_jal = (opcode == OP_JAL);
    assign is_lui = (opcode == OP_LUI);
    assign legal  = is_r || is_i || is_ld || is_sd || is_br || is_jal || is_lui;

    // Shared R/I-ALU function; funct7[5] selects SUB only for register ops.
    logic [3:0] alu_fn;
    always_comb begin
        alu_fn = ULA_ADD;
        case (funct3)
            3'b000:  alu_fn = (is_r && funct7_5) ? ULA_SUB : ULA_ADD;
            3'b001:  alu_fn = ULA_SLL;
            3'b010:  alu_fn = ULA_SLT;
            3'b011:  alu_fn = ULA_SLTU;
            3'b100:  alu_fn = ULA_XOR;
            3'b101:  alu_fn = funct7_5 ? ULA_SRA : ULA_SRL;
            3'b110:  alu_fn = ULA_OR;
            default: alu_fn = ULA_AND;
        endcase
    end

    logic [3:0] op_ula;
    logic       sel_b;
    logic [2:0] tipo;
    logic [1:0] sel_rf;
    always_comb begin
        op_ula = ULA_ADD;
        sel_b  = 1'b1;
        tipo   = IMM_I;
        sel_rf = 2'd0;
        if (is_r) begin
            op_ula = alu_fn;
            sel_b  = 1'b0;
        end else if (is_i) begin
            op_ula = alu_fn;
        end else if (is_sd) begin
            tipo = IMM_S;
        end else if (is_br) begin
            op_ula = ULA_SUB;
            sel_b  = 1'b0;
            tipo   = IMM_B;
        end else if (is_lui) begin
            op_ula = ULA_PASS_B;
            tipo   = IMM_U;
        end else if (is_jal) begin
            tipo   = IMM_J;
            sel_rf = 2'd2;
        end
        if (is_ld) begin
            sel_rf = 2'd1;
        end
    end

    always_comb begin
        estado_d = estado_q;
        desvio_d = desvio_q;
        case (estado_q)
            INICIO: estado_d = BUSCA;
            BUSCA: begin
                estado_d = DECOD;
                desvio_d = 1'b0;
            end
            DECOD: begin
                if (legal) begin
                    estado_d = EXEC;
                end else begin
`ifdef CONTROLE_TRAP_EN
                    estado_d = ERRO;
`else
                    estado_d = BUSCA;
`endif
                end
            end
            EXEC: begin
                desvio_d = (is_beq && ctl.zero) || (is_bne && !ctl.zero) || is_jal;
                if (is_br) begin
                    estado_d = BUSCA;
                end else if (is_ld || is_sd) begin
                    estado_d = MEM;
                end else begin
                    estado_d = ESCRITA;
                end
            end
            MEM:     estado_d = is_ld ? ESCRITA : BUSCA;
            ESCRITA: estado_d = BUSCA;
`ifdef CONTROLE_TRAP_EN
            ERRO:    estado_d = ERRO;
`endif
            default: estado_d = INICIO;
        endcase
        // Strobes are registered from the next state so they line up with it glitch-free.
        atualiza_pc_d = (estado_d == BUSCA);
        wedm_d        = (estado_d == MEM) && is_sd;
        werf_d        = (estado_d == ESCRITA) && (rd != 5'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q      <= INICIO;
            atualiza_pc_q <= 1'b0;
            wedm_q        <= 1'b0;
            werf_q        <= 1'b0;
            desvio_q      <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            atualiza_pc_q <= atualiza_pc_d;
            wedm_q        <= wedm_d;
            werf_q        <= werf_d;
            desvio_q      <= desvio_d;
        end
    end

    assign ctl.atualiza_pc = atualiza_pc_q;
    assign ctl.WeDM        = wedm_q;
    assign ctl.WeRF        = werf_q;
    assign ctl.selPC       = desvio_q && (estado_q == BUSCA);
    assign ctl.selULA_B    = sel_b;
    assign ctl.selRF       = sel_rf;
    assign ctl.opULA       = op_ula;
    assign ctl.tipo_imm    = tipo;
    assign ctl.estado      = estado_q;
`ifdef CONTROLE_TRAP_EN
    assign ctl.erro        = (estado_q == ERRO);
`else
    assign ctl.erro        = 1'b0;
`endif
endmodule
